seg_display_mux: RTL
====================

Name: seg_display_mux

Overview:
- Parametrised successor to the board-level hex readout: shows one of N_CH 32-bit-style status words (cycle counters, parameters, a0, etc.) on DIGITS seven-segment digits.
- Replaces the raw switch select with a debounced "next" button, an optional auto-rotate mode, a freeze/snapshot switch and optional leading-zero blanking.
- Sits between top_riscv status outputs and the board seven-segment pins.

Parameters:
- N_CH, 4, number of input channels (2..16; need not be a power of two).
- DIGITS, 8, hex digits per channel; channel width = 4*DIGITS bits.
- DEBOUNCE_CYCLES, 500000, consecutive stable synced samples required to accept a button level change.
- ROTATE_CYCLES, 100000000, cycles between automatic channel advances in auto mode.
- BLANK_LZ, 0, 1 = blank leading zero digits (digit 0 is never blanked).
- BLANK_PATTERN, 7'b1111111, segment pattern driven for a blanked digit (board is active-low).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- ch_data  input  N_CH*4*DIGITS  channel c occupies bits [c*4*DIGITS +: 4*DIGITS].
- next_btn  input  1  raw, asynchronous push button; a press advances the channel.
- auto_sw  input  1  raw switch; 1 = auto-rotate channels.
- freeze_sw  input  1  raw switch; 1 = hold the displayed value.
- seven_segs  output  7*DIGITS  digit i on bits [i*7 +: 7], encoded by the existing seven_seg decoder.
- ch_sel  output  max(1,clog2(N_CH))  currently selected channel index.
- frozen  output  1  display is holding a snapshot (LED).

Behaviour:
- Reset: every register is cleared on clk edge while rst=1, including ch_sel, disp_reg, sync/debounce/rotate counters, debounced button and frozen.
  - ch_sel=0, frozen=0, disp_reg=0.
  - seven_segs shows all-"0" digits; with BLANK_LZ=1, digits 1..DIGITS-1 show BLANK_PATTERN.
  - Reset mid-count discards any pending press or rotate tick.
- Synchronisers: next_btn, auto_sw and freeze_sw each pass through 2 flops before use. All timing below is counted from the synchronised signal.
- Debounce:
  - Counter increments while btn_sync != btn_db.
  - Counter clears whenever btn_sync == btn_db.
  - When the counter reaches DEBOUNCE_CYCLES-1 with inequality, btn_db takes btn_sync and the counter clears.
  - A 0->1 transition of btn_db produces a one-cycle press pulse.
- Channel select:
  - A press pulse advances ch_sel by 1 on the next edge.
  - Wrap rule: N_CH-1 -> 0. ch_sel never holds a value >= N_CH.
- Auto-rotate:
  - When auto_sync=1, rot_cnt counts 0..ROTATE_CYCLES-1; the tick fires at the terminal count and rot_cnt returns to 0.
  - rot_cnt is held at 0 while auto_sync=0.
  - A press pulse also clears rot_cnt, so a manual advance restarts the rotate period.
  - Press pulse and tick in the same cycle: advance by exactly 1.
- Display register:
  - Each cycle, disp_reg <= ch_data[ch_sel] unless frozen=1.
  - seven_segs is combinational from disp_reg, so ch_data to display latency is 1 cycle after ch_sel settles.
  - A channel change appears on the display 1 cycle after ch_sel updates.
- Freeze:
  - frozen <= freeze_sync.
  - While frozen=1, disp_reg holds. ch_sel may still change (button or auto) and ch_sel reflects it.
  - On release, disp_reg reloads from the currently selected channel on the first edge with frozen=0.
- Blanking (BLANK_LZ=1): digit i (i>=1) is blanked iff disp_reg nibbles i..DIGITS-1 are all zero. A value of 0 shows a single "0".
- Widths: ch_sel width is max(1,clog2(N_CH)). Counters are sized by clog2 of their terminal count plus 1.

Test Plan (bench uses N_CH=3, DIGITS=8, DEBOUNCE_CYCLES=4, ROTATE_CYCLES=10):
- Reset then release with ch_data = {0x00000000, 0x0000ABCD, 0x12345678} (ch0 = 0x12345678) -> after 1 cycle, seven_segs decodes 1,2,3,4,5,6,7,8; ch_sel=0; frozen=0.
- Button bounce: next_btn toggles 1/0 every 2 cycles for 12 cycles, then held 1 -> exactly one advance, ch_sel=1 exactly 2+4+1 cycles after the stable high begins, display 0x0000ABCD one cycle later.
- Wrap: three clean presses from ch_sel=0 -> sequence 1, 2, 0. Never 3.
- Auto mode: auto_sw=1 -> ch_sel advances every 10 cycles. A manual press 5 cycles into a period advances once and the next auto advance comes 10 cycles after the press. A press aligned with the tick gives a single advance.
- Freeze: display 0x12345678, freeze_sw=1, then change ch_data ch0 to 0xDEADBEEF and press to ch1 -> display stays 12345678, ch_sel=1. After freeze_sw=0 plus sync delay, display shows 0x0000ABCD.
- BLANK_LZ=1 with ch1=0x0000ABCD -> digits 7..4 = BLANK_PATTERN, digits 3..0 = A,B,C,D. Channel value 0 -> only digit 0 shows "0". Asserting rst mid-debounce -> ch_sel=0 and no late advance.

Source files
------------

// File: rtl/seg_display_mux.sv
// Seven-segment readout multiplexer: picks one of N_CH status words with a
// debounced "next" button or a periodic auto-rotate, and can freeze the
// shown value. Optional leading-zero blanking. Segments are active-low.
module seg_display_mux #(
    parameter int          N_CH            = 4,
    parameter int          DIGITS          = 8,
    parameter int          DEBOUNCE_CYCLES = 500000,
    parameter int          ROTATE_CYCLES   = 100000000,
    parameter int          BLANK_LZ        = 0,
    parameter logic [6:0]  BLANK_PATTERN   = 7'b1111111,
    localparam int         CH_W            = ($clog2(N_CH) > 1) ? $clog2(N_CH) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_CH*4*DIGITS-1:0]   ch_data,
    input  logic                       next_btn,
    input  logic                       auto_sw,
    input  logic                       freeze_sw,
    output logic [7*DIGITS-1:0]        seven_segs,
    output logic [CH_W-1:0]            ch_sel,
    output logic                       frozen
);

    localparam int W     = 4 * DIGITS;
    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int ROT_W = $clog2(ROTATE_CYCLES) + 1;

    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [ROT_W-1:0] ROT_LAST = ROT_W'(ROTATE_CYCLES - 1);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(N_CH - 1);

    // Synchroniser bit order: {freeze, auto, btn}
    logic [2:0]       sync1_q, sync1_d;
    logic [2:0]       sync2_q, sync2_d;
    logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic             btn_db_q, btn_db_d;
    logic             btn_db_prev_q, btn_db_prev_d;
    logic [ROT_W-1:0] rot_cnt_q, rot_cnt_d;
    logic [CH_W-1:0]  ch_sel_q, ch_sel_d;
    logic             frozen_q, frozen_d;
    logic [W-1:0]     disp_q, disp_d;

    logic             btn_sync, auto_sync, freeze_sync;
    logic             press, tick;
    logic [W-1:0]     sel_word;

    assign btn_sync    = sync2_q[0];
    assign auto_sync   = sync2_q[1];
    assign freeze_sync = sync2_q[2];

    // One-cycle pulse on the rising edge of the debounced button
    assign press = btn_db_q & ~btn_db_prev_q;
    assign tick  = auto_sync && (rot_cnt_q == ROT_LAST);

    // Active-low hex decoder, segment a on bit 0 through g on bit 6
    function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Channel mux; compare-based so a non-power-of-two N_CH never indexes past the bus
    always_comb begin
        sel_word = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (ch_sel_q == CH_W'(c)) sel_word = ch_data[c*W +: W];
        end
    end

    // Next-state: sync chain, debounce, channel advance, rotate timer, display
    always_comb begin
        sync1_d = {freeze_sw, auto_sw, next_btn};
        sync2_d = sync1_q;

        btn_db_d = btn_db_q;
        db_cnt_d = '0;
        if (btn_sync != btn_db_q) begin
            if (db_cnt_q == DB_LAST) btn_db_d = btn_sync;
            else                     db_cnt_d = db_cnt_q + 1'b1;
        end
        btn_db_prev_d = btn_db_q;

        // Press and tick together still advance only once
        ch_sel_d = ch_sel_q;
        if (press || tick) ch_sel_d = (ch_sel_q == CH_LAST) ? '0 : ch_sel_q + 1'b1;

        // A manual press restarts the rotate period
        rot_cnt_d = (auto_sync && !press && !tick) ? rot_cnt_q + 1'b1 : '0;

        frozen_d = freeze_sync;
        disp_d   = frozen_q ? disp_q : sel_word;
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            db_cnt_q      <= '0;
            btn_db_q      <= 1'b0;
            btn_db_prev_q <= 1'b0;
            rot_cnt_q     <= '0;
            ch_sel_q      <= '0;
            frozen_q      <= 1'b0;
            disp_q        <= '0;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            db_cnt_q      <= db_cnt_d;
            btn_db_q      <= btn_db_d;
            btn_db_prev_q <= btn_db_prev_d;
            rot_cnt_q     <= rot_cnt_d;
            ch_sel_q      <= ch_sel_d;
            frozen_q      <= frozen_d;
            disp_q        <= disp_d;
        end
    end

    // Per-digit decode; digit i blanks when it and every higher nibble are zero
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        logic blank;
        if (BLANK_LZ != 0 && i > 0) begin : g_lz
            assign blank = ~|disp_q[W-1:4*i];
        end else begin : g_nolz
            assign blank = 1'b0;
        end
        assign seven_segs[7*i +: 7] = blank ? BLANK_PATTERN : hex_to_seg(disp_q[4*i +: 4]);
    end

    assign ch_sel = ch_sel_q;
    assign frozen = frozen_q;

endmodule
